execution_pipe: RTL



---
 rtl/execution_pkg.sv | 35 +++
 rtl/execution_pipe_if.sv | 30 +++
 rtl/iter_mult.sv | 90 +++++++++
 rtl/execution_pipe.sv | 126 ++++++++++++
 4 files changed

// File: rtl/execution_pkg.sv
// Shared definitions for the EX stage: ALU operation codes, multiplier FSM states
// and the immediate sign-extension helper.
package execution_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_BEQ  = 4'b1011;
    localparam logic [3:0] ALU_BNE  = 4'b1100;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_MFHI = 4'b1110;
    localparam logic [3:0] ALU_MFLO = 4'b1111;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Sign-extends the low imm_w bits to 64; callers truncate to their datapath width.
    function automatic logic [63:0] sext(input logic [63:0] imm, input int imm_w);
        logic signed [63:0] t;
        t = imm << (64 - imm_w);
        return t >>> (64 - imm_w);
    endfunction

endpackage

// File: rtl/execution_pipe_if.sv
// DX-to-XM bundle of the EX stage, including the stall/flush/busy hazard handshake.
interface execution_pipe_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int RD_W  = 5
);
    logic             DX_valid, DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch;
    logic [3:0]       ALUctr;
    logic [XLEN-1:0]  NPC, A, B, DX_MD;
    logic [IMM_W-1:0] imm;
    logic [RD_W-1:0]  DX_RD;
    logic             stall, flush, busy;
    logic             XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
    logic [XLEN-1:0]  ALUout, XM_BT, XM_MD;
    logic [RD_W-1:0]  XM_RD;

    modport master (
        output DX_valid, DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch,
               ALUctr, NPC, A, B, imm, DX_RD, DX_MD, stall, flush,
        input  busy, XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
               ALUout, XM_BT, XM_RD, XM_MD
    );

    modport slave (
        input  DX_valid, DX_MemtoReg, DX_RegWrite, DX_MemRead, DX_MemWrite, DX_branch,
               ALUctr, NPC, A, B, imm, DX_RD, DX_MD, stall, flush,
        output busy, XM_valid, XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
               ALUout, XM_BT, XM_RD, XM_MD
    );
endinterface

// File: rtl/iter_mult.sv
// Iterative signed multiplier: sign-magnitude shift-add, one partial product per cycle,
// sign fixed up on the way out so the product is valid while done_o is high.
module iter_mult #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              hold_i,
    input  logic              abort_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o
);
    import execution_pkg::*;

    localparam int CW = $clog2(XLEN);

    mul_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     sum_d;
    logic              neg_q, busy_q, done_q;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

    // Upper half accumulates, lower half holds the multiplier bits still to consume.
    always_comb begin
        sum_d = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d = {sum_d, acc_q[XLEN-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (!hold_i) begin
            if (abort_i && state_q != MUL_IDLE) begin
                state_q <= MUL_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    MUL_IDLE: begin
                        if (start_i) begin
                            state_q <= MUL_RUN;
                            cnt_q   <= CW'(XLEN - 1);
                            mcand_q <= mag(a_i);
                            acc_q   <= {{XLEN{1'b0}}, mag(b_i)};
                            neg_q   <= a_i[XLEN-1] ^ b_i[XLEN-1];
                            busy_q  <= 1'b1;
                        end
                    end
                    MUL_RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= MUL_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    MUL_DONE: begin
                        state_q <= MUL_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= MUL_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = neg_q ? (~acc_q + 1'b1) : acc_q;
endmodule

// File: rtl/execution_pipe.sv
// MIPS EX stage: single-cycle ALU/branch resolution into the XM register, plus an
// optional multi-cycle MULT writing HI/LO with stall/flush hazard control.
module execution_pipe #(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 16,
    parameter int RD_W   = 5,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    execution_pipe_if.slave pipe
);
    import execution_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] imm_ext, alu_res_d, hi_q, lo_q;
    logic [SHW-1:0]  shamt;
    logic            is_mult, br_taken_d, mul_busy, mul_start;

    logic            xm_valid_q, xm_memtoreg_q, xm_regwrite_q;
    logic            xm_memread_q, xm_memwrite_q, xm_branch_q;
    logic [XLEN-1:0] alu_out_q, xm_bt_q, xm_md_q;
    logic [RD_W-1:0] xm_rd_q;

    assign imm_ext   = XLEN'(sext(64'(pipe.imm), IMM_W));
    assign shamt     = pipe.B[SHW-1:0];
    assign is_mult   = (pipe.ALUctr == ALU_MULT);
    assign mul_start = pipe.DX_valid & is_mult & ~pipe.stall & ~pipe.flush & ~mul_busy;
    assign br_taken_d = pipe.DX_branch & pipe.DX_valid &
                        (((pipe.ALUctr == ALU_BEQ) & (pipe.A == pipe.B)) |
                         ((pipe.ALUctr == ALU_BNE) & (pipe.A != pipe.B)));

    always_comb begin
        alu_res_d = '0;
        case (pipe.ALUctr)
            ALU_AND:  alu_res_d = pipe.A & pipe.B;
            ALU_OR:   alu_res_d = pipe.A | pipe.B;
            ALU_ADD:  alu_res_d = pipe.A + pipe.B;
            ALU_XOR:  alu_res_d = pipe.A ^ pipe.B;
            ALU_NOR:  alu_res_d = ~(pipe.A | pipe.B);
            ALU_SLTU: alu_res_d = XLEN'(pipe.A < pipe.B);
            ALU_SUB:  alu_res_d = pipe.A - pipe.B;
            ALU_SLT:  alu_res_d = XLEN'($signed(pipe.A) < $signed(pipe.B));
            ALU_SLL:  alu_res_d = pipe.A << shamt;
            ALU_SRL:  alu_res_d = pipe.A >> shamt;
            ALU_SRA:  alu_res_d = $signed(pipe.A) >>> shamt;
            ALU_MFHI: alu_res_d = hi_q;
            ALU_MFLO: alu_res_d = lo_q;
            default:  alu_res_d = '0;
        endcase
    end

    // A running multiply owns the stage, so XM sees bubbles until it finishes.
    always_ff @(posedge clk) begin
        if (rst || (!pipe.stall && (pipe.flush || mul_busy))) begin
            xm_valid_q    <= 1'b0;
            xm_memtoreg_q <= 1'b0;
            xm_regwrite_q <= 1'b0;
            xm_memread_q  <= 1'b0;
            xm_memwrite_q <= 1'b0;
            xm_branch_q   <= 1'b0;
            alu_out_q     <= '0;
            xm_bt_q       <= '0;
            xm_rd_q       <= '0;
            xm_md_q       <= '0;
        end else if (!pipe.stall) begin
            xm_valid_q    <= pipe.DX_valid;
            xm_memtoreg_q <= pipe.DX_MemtoReg;
            xm_regwrite_q <= pipe.DX_RegWrite & ~is_mult;
            xm_memread_q  <= pipe.DX_MemRead;
            xm_memwrite_q <= pipe.DX_MemWrite;
            xm_branch_q   <= br_taken_d;
            alu_out_q     <= alu_res_d;
            xm_bt_q       <= pipe.NPC + (imm_ext << 2);
            xm_rd_q       <= pipe.DX_RD;
            xm_md_q       <= pipe.DX_MD;
        end
    end

    generate
        if (MUL_EN != 0) begin : g_mul
            logic              mul_done;
            logic [2*XLEN-1:0] mul_prod;

            iter_mult #(.XLEN(XLEN)) u_iter_mult (
                .clk       (clk),
                .rst       (rst),
                .start_i   (mul_start),
                .hold_i    (pipe.stall),
                .abort_i   (pipe.flush),
                .a_i       (pipe.A),
                .b_i       (pipe.B),
                .busy_o    (mul_busy),
                .done_o    (mul_done),
                .product_o (mul_prod)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end else if (mul_done && !pipe.stall && !pipe.flush) begin
                    hi_q <= mul_prod[2*XLEN-1:XLEN];
                    lo_q <= mul_prod[XLEN-1:0];
                end
            end
        end else begin : g_no_mul
            assign mul_busy = 1'b0;
            assign hi_q     = '0;
            assign lo_q     = '0;
        end
    endgenerate

    assign pipe.busy        = mul_busy;
    assign pipe.XM_valid    = xm_valid_q;
    assign pipe.XM_MemtoReg = xm_memtoreg_q;
    assign pipe.XM_RegWrite = xm_regwrite_q;
    assign pipe.XM_MemRead  = xm_memread_q;
    assign pipe.XM_MemWrite = xm_memwrite_q;
    assign pipe.XM_branch   = xm_branch_q;
    assign pipe.ALUout      = alu_out_q;
    assign pipe.XM_BT       = xm_bt_q;
    assign pipe.XM_RD       = xm_rd_q;
    assign pipe.XM_MD       = xm_md_q;
endmodule
